stream_fifo_wm: RTL and testbench

//  Parametrised successor to stream_fifo: valid/ready stream FIFO with any DEPTH >= 2 (non-power-of-2 allowed).

---
 rtl/stream_fifo_wm.sv | 133 +++++++++++++
 tb/tb_stream_fifo_wm.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_fifo_wm.sv
// Valid/ready stream FIFO for any DEPTH >= 2 (non-power-of-2 allowed), with first-word-fall-through output.
// Also provides almost-full/almost-empty thresholds, synchronous flush, sticky error flags and a high-watermark.
module stream_fifo_wm #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AF_THRESH  = DEPTH - 1,
    parameter int AE_THRESH  = 1,
    localparam int LW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    input  logic                  flush,
    input  logic                  clr_flags,
    output logic [LW-1:0]         level,
    output logic [LW-1:0]         max_level,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int            PW       = $clog2(DEPTH);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [LW-1:0] ZERO_LVL = {LW{1'b0}};
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [PW-1:0] ZERO_PTR = {PW{1'b0}};

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic [LW-1:0]         max_level_q, max_level_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  full_s, empty_s, push_s, pop_s, ovf_set_s, unf_set_s;

    // Explicit wrap keeps pointers inside 0..DEPTH-1 for any depth.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == LAST_PTR) begin
            return ZERO_PTR;
        end else begin
            return p + PW'(1);
        end
    endfunction

    assign full_s    = (level_q == FULL_LVL);
    assign empty_s   = (level_q == ZERO_LVL);
    assign push_s    = s_valid & ~full_s;
    assign pop_s     = m_ready & ~empty_s;
    assign ovf_set_s = s_valid & full_s & ~flush;
    assign unf_set_s = m_ready & empty_s & ~flush;

    // Next-state: occupancy, pointers, sticky flags and watermark; flush overrides any handshake.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        max_level_d = max_level_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (flush) begin
            wr_ptr_d = ZERO_PTR;
            rd_ptr_d = ZERO_PTR;
            level_d  = ZERO_LVL;
        end else begin
            if (push_s) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
        if (clr_flags) begin
            overflow_d  = ovf_set_s;
            underflow_d = unf_set_s;
            max_level_d = level_d;
        end else begin
            overflow_d  = overflow_q | ovf_set_s;
            underflow_d = underflow_q | unf_set_s;
            max_level_d = (level_d > max_level_q) ? level_d : max_level_q;
        end
    end

    // Control and status state with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= ZERO_PTR;
            rd_ptr_q    <= ZERO_PTR;
            level_q     <= ZERO_LVL;
            max_level_q <= ZERO_LVL;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            max_level_q <= max_level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Payload storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (push_s && !flush) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

    assign s_ready      = ~full_s;
    assign m_valid      = ~empty_s;
    assign m_data       = mem_q[rd_ptr_q];
    assign level        = level_q;
    assign max_level    = max_level_q;
    assign almost_full  = (level_q >= LW'(AF_THRESH));
    assign almost_empty = (level_q <= LW'(AE_THRESH));
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
endmodule

// File: tb/tb_stream_fifo_wm.sv
// Bench for stream_fifo_wm: a DEPTH=8 and a DEPTH=5 instance share one stimulus stream and are
// compared every cycle against a ring-buffer occupancy model, plus hand-computed spot checks.
module tb_stream_fifo_wm;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       m_ready = 1'b0;
    logic       flush = 1'b0;
    logic       clr_flags = 1'b0;

    logic       sr8, mv8, af8, ae8, ov8, uf8;
    logic [7:0] md8;
    logic [3:0] lvl8, mx8;
    logic       sr5, mv5, af5, ae5, ov5, uf5;
    logic [7:0] md5;
    logic [2:0] lvl5, mx5;

    int passed = 0;
    int total  = 0;

    int dep [2] = '{8, 5};
    int afth[2] = '{7, 4};
    int aeth[2] = '{1, 2};
    int mcnt[2] = '{0, 0};
    int mhead[2] = '{0, 0};
    int mmax[2] = '{0, 0};
    bit mov[2] = '{1'b0, 1'b0};
    bit muf[2] = '{1'b0, 1'b0};
    logic [7:0] mbuf[2][8];

    always #5 clk = ~clk;

    stream_fifo_wm #(.DATA_WIDTH(8), .DEPTH(8)) u_d8 (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_ready(sr8),
        .m_valid(mv8), .m_data(md8), .m_ready(m_ready), .flush(flush), .clr_flags(clr_flags),
        .level(lvl8), .max_level(mx8), .almost_full(af8), .almost_empty(ae8),
        .overflow(ov8), .underflow(uf8)
    );

    stream_fifo_wm #(.DATA_WIDTH(8), .DEPTH(5), .AF_THRESH(4), .AE_THRESH(2)) u_d5 (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_ready(sr5),
        .m_valid(mv5), .m_data(md5), .m_ready(m_ready), .flush(flush), .clr_flags(clr_flags),
        .level(lvl5), .max_level(mx5), .almost_full(af5), .almost_empty(ae5),
        .overflow(ov5), .underflow(uf5)
    );

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Occupancy model: a ring buffer plus counters, updated from the inputs seen at each edge.
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            bit os, us, pu, po;
            os = 1'b0; us = 1'b0; pu = 1'b0; po = 1'b0;
            if (!rst_n) begin
                mcnt[k] = 0; mhead[k] = 0; mmax[k] = 0; mov[k] = 1'b0; muf[k] = 1'b0;
            end else begin
                if (flush) begin
                    mcnt[k] = 0;
                    mhead[k] = 0;
                end else begin
                    os = s_valid && (mcnt[k] == dep[k]);
                    us = m_ready && (mcnt[k] == 0);
                    pu = s_valid && (mcnt[k] < dep[k]);
                    po = m_ready && (mcnt[k] > 0);
                    if (po) begin
                        mhead[k] = (mhead[k] + 1) % dep[k];
                        mcnt[k]--;
                    end
                    if (pu) begin
                        mbuf[k][(mhead[k] + mcnt[k]) % dep[k]] = s_data;
                        mcnt[k]++;
                    end
                end
                if (clr_flags) begin
                    mov[k] = os; muf[k] = us; mmax[k] = mcnt[k];
                end else begin
                    mov[k] = mov[k] | os; muf[k] = muf[k] | us;
                    if (mcnt[k] > mmax[k]) mmax[k] = mcnt[k];
                end
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) model_step();

    // Every-cycle comparison of both instances against the model, away from the rising edge.
    always @(negedge clk) begin
        chk("d8 level", int'(lvl8), mcnt[0]);
        chk("d8 m_valid", int'(mv8), int'(mcnt[0] != 0));
        chk("d8 s_ready", int'(sr8), int'(mcnt[0] < dep[0]));
        chk("d8 almost_full", int'(af8), int'(mcnt[0] >= afth[0]));
        chk("d8 almost_empty", int'(ae8), int'(mcnt[0] <= aeth[0]));
        chk("d8 overflow", int'(ov8), int'(mov[0]));
        chk("d8 underflow", int'(uf8), int'(muf[0]));
        chk("d8 max_level", int'(mx8), mmax[0]);
        if (mcnt[0] != 0) chk("d8 m_data", int'(md8), int'(mbuf[0][mhead[0]]));
        chk("d5 level", int'(lvl5), mcnt[1]);
        chk("d5 m_valid", int'(mv5), int'(mcnt[1] != 0));
        chk("d5 s_ready", int'(sr5), int'(mcnt[1] < dep[1]));
        chk("d5 almost_full", int'(af5), int'(mcnt[1] >= afth[1]));
        chk("d5 almost_empty", int'(ae5), int'(mcnt[1] <= aeth[1]));
        chk("d5 overflow", int'(ov5), int'(mov[1]));
        chk("d5 underflow", int'(uf5), int'(muf[1]));
        chk("d5 max_level", int'(mx5), mmax[1]);
        if (mcnt[1] != 0) chk("d5 m_data", int'(md5), int'(mbuf[1][mhead[1]]));
    end

    task automatic drive(input bit sv, input logic [7:0] d, input bit mr, input bit fl, input bit cl);
        s_valid = sv; s_data = d; m_ready = mr; flush = fl; clr_flags = cl;
        @(posedge clk);
        #1;
    endtask

    int t1_exp[3]    = '{8'h11, 8'h22, 8'h33};
    int af5_tab[6]   = '{0, 0, 0, 0, 1, 1};
    int ae5_tab[6]   = '{1, 1, 1, 0, 0, 0};

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset level", int'(lvl8), 0);
        chk("reset s_ready", int'(sr8), 1);
        chk("reset m_valid", int'(mv8), 0);
        chk("reset almost_empty", int'(ae8), 1);
        chk("reset almost_full", int'(af8), 0);
        rst_n = 1'b1;

        // T1: first-word-fall-through and ordering
        drive(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        chk("T1 m_valid after first push", int'(mv8), 1);
        chk("T1 head after first push", int'(md8), 8'h11);
        drive(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
        chk("T1 level", int'(lvl8), 3);
        for (int i = 0; i < 3; i++) begin
            chk("T1 pop order", int'(md8), t1_exp[i]);
            drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        chk("T1 empty after pops", int'(mv8), 0);

        // T2: fill to full, overflow attempt, drain
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
            if (i == 6) begin
                chk("T2 level 7", int'(lvl8), 7);
                chk("T2 almost_full at 7", int'(af8), 1);
                chk("T2 s_ready at 7", int'(sr8), 1);
            end
        end
        chk("T2 s_ready full", int'(sr8), 0);
        drive(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        chk("T2 overflow", int'(ov8), 1);
        chk("T2 level stays 8", int'(lvl8), 8);
        for (int i = 0; i < 8; i++) begin
            chk("T2 drain data", int'(md8), i);
            drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        chk("T2 empty after drain", int'(mv8), 0);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("T2 overflow cleared", int'(ov8), 0);
        chk("T2 max_level cleared", int'(mx8), 0);

        // T3: continuous simultaneous push/pop across several wraps
        drive(1'b1, 8'd100, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'd101, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 24; i++) drive(1'b1, 8'(102 + i), 1'b1, 1'b0, 1'b0);
        chk("T3 level constant", int'(lvl8), 2);
        chk("T3 head after stream", int'(md8), 124);
        chk("T3 no overflow", int'(ov8), 0);
        chk("T3 no underflow", int'(uf8), 0);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // T4: underflow, then clear reloads max_level with current level
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("T4 underflow", int'(uf8), 1);
        drive(1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'h42, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'h43, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("T4 max before clear", int'(mx8), 3);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("T4 underflow cleared", int'(uf8), 0);
        chk("T4 max reloaded", int'(mx8), 2);

        // T5: flush with handshakes active
        for (int i = 0; i < 3; i++) drive(1'b1, 8'(8'h50 + i), 1'b0, 1'b0, 1'b0);
        chk("T5 level before flush", int'(lvl8), 5);
        drive(1'b1, 8'h55, 1'b1, 1'b1, 1'b0);
        chk("T5 level after flush", int'(lvl8), 0);
        chk("T5 m_valid after flush", int'(mv8), 0);
        chk("T5 max kept", int'(mx8), 5);
        chk("T5 no overflow d8", int'(ov8), 0);
        chk("T5 no overflow d5 full", int'(ov5), 0);
        chk("T5 no underflow", int'(uf8), 0);

        // T6: DEPTH=5 threshold stepping up and down
        for (int l = 1; l <= 5; l++) begin
            drive(1'b1, 8'(8'h60 + l), 1'b0, 1'b0, 1'b0);
            chk("T6 up level", int'(lvl5), l);
            chk("T6 up almost_full", int'(af5), af5_tab[l]);
            chk("T6 up almost_empty", int'(ae5), ae5_tab[l]);
        end
        chk("T6 s_ready full", int'(sr5), 0);
        for (int l = 4; l >= 0; l--) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            chk("T6 down level", int'(lvl5), l);
            chk("T6 down almost_full", int'(af5), af5_tab[l]);
            chk("T6 down almost_empty", int'(ae5), ae5_tab[l]);
        end
        for (int i = 0; i < 3; i++) drive(1'b1, 8'(8'h70 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) drive(1'b1, 8'(8'h80 + i), 1'b1, 1'b0, 1'b0);
        chk("T6 wrap head", int'(md5), 8'h84);
        for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a burst
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b1, 8'(8'h90 + i), 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ARST level", int'(lvl8), 0);
        chk("ARST m_valid", int'(mv8), 0);
        chk("ARST s_ready", int'(sr8), 1);
        chk("ARST almost_empty", int'(ae8), 1);
        chk("ARST almost_full", int'(af8), 0);
        chk("ARST underflow", int'(uf8), 0);
        chk("ARST max_level", int'(mx8), 0);
        chk("ARST d5 level", int'(lvl5), 0);
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
        chk("post-reset push", int'(md8), 8'hC3);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
